cache_ctrl_wb: RTL
==================

CACHE_CTRL_WB -- requirements
Module: cache_ctrl_wb

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, meaning words per cache line and memory beats per transfer, legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 4, meaning beat-counter width, legal values satisfy 2^CNT_W >= BURST_LEN.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req  input  1  CPU memory instruction valid this cycle.
REQ-006 SHALL have port write_en  input  1  CPU access is a store.
REQ-007 SHALL have port hit  input  1  tag match on the addressed line.
REQ-008 SHALL have port dirty_bit  input  1  victim line modified.
REQ-009 SHALL have port mem_ready  input  1  memory accepts (write) or returns (read) one beat this cycle.
REQ-010 SHALL have port stall  output  1  freeze CPU pipeline.
REQ-011 SHALL have port mem_wr / mem_rd  output  1 each  memory write / read beat request.
REQ-012 SHALL have port beat_idx  output  CNT_W  word index within line for current beat.
REQ-013 SHALL have port wb_sel  output  1  address mux selects victim tag (1) or CPU tag (0).
REQ-014 SHALL have port fill_we  output  1  write returned beat into cache data array.
REQ-015 SHALL have port line_done  output  1  set valid, clear dirty, write new tag.
REQ-016 SHALL have port overwrite_data  output  1  store hit writes CPU data into cache.
REQ-017 SHALL have ports miss_count, wb_count  output  16 each  performance counters.

Function
REQ-018 SHALL implement states IDLE, WRITEBACK, REFILL, DONE, with one-hot or binary encoding at implementer's choice.
REQ-019 SHALL transition IDLE: req && !hit && dirty_bit -> WRITEBACK; req && !hit && !dirty_bit -> REFILL; else stay; beat counter cleared to 0 on either exit.
REQ-020 SHALL, in WRITEBACK, assert mem_wr and wb_sel=1, advance the counter only on mem_ready, and on mem_ready with counter==BURST_LEN-1 go to REFILL with counter=0.
REQ-021 SHALL, in REFILL, assert mem_rd, assert fill_we combinationally equal to mem_ready, advance the counter on mem_ready, and on the last beat go to DONE.
REQ-022 SHALL, in DONE, assert line_done for exactly one cycle and return to IDLE.
REQ-023 SHALL hold the counter and state while mem_ready=0; no timeout.
REQ-024 SHALL drive beat_idx = counter in WRITEBACK/REFILL, and 0 otherwise.
REQ-025 SHALL drive stall = (state!=IDLE) || (req && !hit).
REQ-026 SHALL drive overwrite_data = IDLE && req && hit && write_en, and 0 in every other state.
REQ-027 SHALL ignore req, hit, dirty_bit and write_en outside IDLE.
REQ-028 SHALL drive wb_sel=0 outside WRITEBACK.
REQ-029 SHALL give miss latency with mem_ready held high of BURST_LEN+2 cycles clean, or 2*BURST_LEN+2 cycles dirty, from miss detect to IDLE.

Reset
REQ-030 SHALL, on reset low at any time including mid-burst, immediately force state=IDLE, counter=0, all outputs 0 except stall=(req && !hit), and miss_count=wb_count=0.
REQ-031 SHALL resume normal operation on the first rising clk after reset deasserts.

Configuration
REQ-032 SHALL gate counters with macro CACHE_CTRL_PERF_EN.
REQ-033 SHALL, with CACHE_CTRL_PERF_EN defined, increment miss_count on each IDLE exit and wb_count on each IDLE->WRITEBACK, both saturating at 16'hFFFF.
REQ-034 SHALL, without CACHE_CTRL_PERF_EN, keep the ports present, tie them to 0, and synthesise no counter flops.

Verification
REQ-035 SHALL cover store hit: req=1, hit=1, write_en=1 in IDLE -> overwrite_data=1, stall=0, state stays IDLE.
REQ-036 SHALL cover clean miss with BURST_LEN=4 and mem_ready=1: 4 mem_rd cycles, beat_idx 0,1,2,3, fill_we each cycle, line_done on cycle 5, IDLE on cycle 6.
REQ-037 SHALL cover dirty miss with BURST_LEN=4: 4 mem_wr cycles with wb_sel=1, then 4 REFILL beats, then line_done; wb_count=1 and miss_count=1 with PERF_EN.
REQ-038 SHALL cover backpressure: mem_ready toggling 1,0,0,1 in REFILL -> beat_idx holds at 1 during the stalled cycles, and fill_we is asserted only on ready cycles.
REQ-039 SHALL cover reset mid-WRITEBACK at beat 2 -> next sampled state IDLE, mem_wr=0, beat_idx=0, and counters 0.
REQ-040 SHALL cover BURST_LEN=16, CNT_W=4: last beat_idx=15 is followed by a REFILL transition without counter overflow.

Source files
------------

// File: rtl/cache_ctrl_wb.sv
// Write-back cache miss controller: optional victim writeback burst, line refill burst, one-cycle commit.
// Performance counters are built only when CACHE_CTRL_PERF_EN is defined; otherwise they read as zero.
module cache_ctrl_wb #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             write_en,
  input  logic             hit,
  input  logic             dirty_bit,
  input  logic             mem_ready,
  output logic             stall,
  output logic             mem_wr,
  output logic             mem_rd,
  output logic [CNT_W-1:0] beat_idx,
  output logic             wb_sel,
  output logic             fill_we,
  output logic             line_done,
  output logic             overwrite_data,
  output logic [15:0]      miss_count,
  output logic [15:0]      wb_count
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] REFILL    = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             miss;
  logic             in_idle;
  logic             in_wb;
  logic             in_refill;

  assign miss      = req && !hit;
  assign in_idle   = (state == IDLE);
  assign in_wb     = (state == WRITEBACK);
  assign in_refill = (state == REFILL);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (miss) begin
          cnt_nxt   = '0;
          state_nxt = dirty_bit ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        if (mem_ready) begin
          if (cnt == LAST_BEAT) begin
            cnt_nxt   = '0;
            state_nxt = REFILL;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      REFILL: begin
        if (mem_ready) begin
          if (cnt == LAST_BEAT) begin
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign stall     = !in_idle || miss;
  assign mem_wr    = in_wb;
  assign wb_sel    = in_wb;
  assign mem_rd    = in_refill;
  assign fill_we   = in_refill && mem_ready;
  assign line_done = (state == DONE);
  assign beat_idx  = (in_wb || in_refill) ? cnt : '0;
  // Gated by reset so a store hit presented during reset cannot write the array.
  assign overwrite_data = reset && in_idle && req && hit && write_en;

`ifdef CACHE_CTRL_PERF_EN
  logic miss_exit;
  assign miss_exit = in_idle && miss;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      miss_count <= '0;
      wb_count   <= '0;
    end else if (miss_exit) begin
      if (miss_count != '1) miss_count <= miss_count + 16'd1;
      if (dirty_bit && (wb_count != '1)) wb_count <= wb_count + 16'd1;
    end
  end
`else
  assign miss_count = '0;
  assign wb_count   = '0;
`endif

endmodule
